// File: rtl/tuner_pkg.sv
// Shared definitions for the tuner sweep controller: register map, FSM encoding
// and the default tuner-slice latency used for valid alignment.
package tuner_pkg;

    localparam int LAT_DEFAULT = 7;

    localparam logic [1:0] ADDR_FSTART = 2'd0;
    localparam logic [1:0] ADDR_FSTOP  = 2'd1;
    localparam logic [1:0] ADDR_FSTEP  = 2'd2;
    localparam logic [1:0] ADDR_DWELL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/valid_delay.sv
// Reset-clearable shift register delaying a strobe by LEN clocks, used to line
// the sample strobe up with the tuner slice output.
module valid_delay #(
    parameter int LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [LEN-1:0] sr_q;
    logic [LEN-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int i = 1; i < LEN; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[LEN-1];

endmodule

// File: rtl/tuner_sweep_ctrl.sv
// Phase accumulator with a programmable linear frequency sweep (FSTART -> FSTOP in
// FSTEP increments, each held for DWELL samples) feeding the tuner slices.
module tuner_sweep_ctrl
    import tuner_pkg::*;
#(
    parameter int ASZ = 26,
    parameter int PSZ = 12,
    parameter int DSZ = 16,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ena,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_addr,
    input  logic [ASZ-1:0] cfg_data,
    output logic           cfg_ready,
    input  logic           start,
    input  logic           abort,
    input  logic           phs_clr,
    output logic [PSZ-1:0] phs,
    output logic           busy,
    output logic           done,
    output logic           out_valid
);

    // Two guard bits: one for the sign of FSTEP, one so an upward step near the
    // top of the range cannot wrap into a negative value before the compare.
    localparam int NSZ = ASZ + 2;

    state_t         state_q, state_d;
    logic [ASZ-1:0] acc_q, acc_d;
    logic [ASZ-1:0] fcur_q, fcur_d;
    logic [DSZ-1:0] dwell_q, dwell_d;
    logic [ASZ-1:0] fstart_q, fstart_d;
    logic [ASZ-1:0] fstop_q, fstop_d;
    logic [ASZ-1:0] fstep_q, fstep_d;
    logic [DSZ-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [PSZ-1:0] phs_q, phs_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cfg_ready_q, cfg_ready_d;

    logic [NSZ-1:0] nxt;
    logic [NSZ-1:0] stop_ext;
    logic           reached;

    always_comb begin
        fstart_d    = fstart_q;
        fstop_d     = fstop_q;
        fstep_d     = fstep_q;
        dwell_cfg_d = dwell_cfg_q;
        if (cfg_we && cfg_ready_q) begin
            case (cfg_addr)
                ADDR_FSTART: fstart_d    = cfg_data;
                ADDR_FSTOP:  fstop_d     = cfg_data;
                ADDR_FSTEP:  fstep_d     = cfg_data;
                ADDR_DWELL:  dwell_cfg_d = cfg_data[DSZ-1:0];
            endcase
        end

        acc_d = acc_q;
        if (phs_clr) begin
            acc_d = '0;
        end else if (ena) begin
            acc_d = acc_q + fcur_q;
        end
        phs_d = acc_d[ASZ-1 -: PSZ];

        nxt      = {2'b00, fcur_q} + {{2{fstep_q[ASZ-1]}}, fstep_q};
        stop_ext = {2'b00, fstop_q};
        if (fstep_q[ASZ-1]) begin
            reached = ($signed(nxt) <= $signed(stop_ext));
        end else begin
            reached = ($signed(nxt) >= $signed(stop_ext));
        end

        state_d = state_q;
        fcur_d  = fcur_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: fcur_d = fstart_d;
            ST_HOLD: fcur_d = fstop_d;
            ST_SWEEP: begin
                if (ena) begin
                    if (dwell_q <= DSZ'(1)) begin
                        if (reached) begin
                            fcur_d  = fstop_q;
                            done_d  = 1'b1;
                            state_d = ST_HOLD;
                        end else begin
                            fcur_d  = nxt[ASZ-1:0];
                            dwell_d = dwell_cfg_q;
                        end
                    end else begin
                        dwell_d = dwell_q - DSZ'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort outranks start; start uses the config as updated this cycle.
        if (abort) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                fcur_d  = fstart_d;
                dwell_d = '0;
                done_d  = 1'b0;
            end
        end else if (start && state_q != ST_SWEEP) begin
            if (fstep_d == '0 || fstart_d == fstop_d) begin
                fcur_d  = fstop_d;
                done_d  = 1'b1;
                state_d = ST_HOLD;
            end else begin
                fcur_d  = fstart_d;
                dwell_d = dwell_cfg_d;
                state_d = ST_SWEEP;
            end
        end

        busy_d      = (state_d == ST_SWEEP);
        cfg_ready_d = (state_d != ST_SWEEP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            fcur_q      <= '0;
            dwell_q     <= '0;
            fstart_q    <= '0;
            fstop_q     <= '0;
            fstep_q     <= '0;
            dwell_cfg_q <= '0;
            phs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fcur_q      <= fcur_d;
            dwell_q     <= dwell_d;
            fstart_q    <= fstart_d;
            fstop_q     <= fstop_d;
            fstep_q     <= fstep_d;
            dwell_cfg_q <= dwell_cfg_d;
            phs_q       <= phs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    valid_delay #(
        .LEN (LAT + 1)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .din   (ena),
        .dout  (out_valid)
    );

    assign phs       = phs_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// Self-checking bench for tuner_sweep_ctrl: a behavioural model feeds a scoreboard
// every cycle, a vector table covers the sweeps, and short sequences cover corners.
module tb_tuner_sweep_ctrl;
    import tuner_pkg::*;

    localparam int ASZ = 26;
    localparam int PSZ = 12;
    localparam int DSZ = 16;
    localparam int LAT = LAT_DEFAULT;

    logic           clk = 1'b0;
    logic           reset;
    logic           ena;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [ASZ-1:0] cfg_data;
    logic           cfg_ready;
    logic           start;
    logic           abort;
    logic           phs_clr;
    logic [PSZ-1:0] phs;
    logic           busy;
    logic           done;
    logic           out_valid;

    always #5 clk = ~clk;

    tuner_sweep_ctrl #(
        .ASZ (ASZ),
        .PSZ (PSZ),
        .DSZ (DSZ),
        .LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .start     (start),
        .abort     (abort),
        .phs_clr   (phs_clr),
        .phs       (phs),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [PSZ-1:0] phs;
        logic           busy;
        logic           done;
        logic           ready;
        logic           ov;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic           we;
        logic [1:0]     addr;
        logic [ASZ-1:0] data;
        logic           start;
        logic           ena;
        int             step;
        logic           busy;
        logic           done;
    } vec_t;
    vec_t tbl[$];

    // Reference model state (0 idle, 1 sweep, 2 hold)
    int             m_state;
    logic [ASZ-1:0] m_acc, m_fcur, m_fstart, m_fstop, m_fstep;
    logic [DSZ-1:0] m_dwcfg;
    longint         m_dwell;
    logic           m_ready, m_done;
    logic [LAT:0]   m_vp;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_clock();
        logic [ASZ-1:0] acc_n;
        longint         step_v, nxt;
        if (reset) begin
            m_state = 0; m_acc = '0; m_fcur = '0; m_fstart = '0; m_fstop = '0;
            m_fstep = '0; m_dwcfg = '0; m_dwell = 0; m_ready = 1'b0; m_done = 1'b0;
            m_vp = '0;
            return;
        end
        acc_n = phs_clr ? '0 : (ena ? m_acc + m_fcur : m_acc);
        if (cfg_we && m_ready) begin
            case (cfg_addr)
                ADDR_FSTART: m_fstart = cfg_data;
                ADDR_FSTOP:  m_fstop  = cfg_data;
                ADDR_FSTEP:  m_fstep  = cfg_data;
                default:     m_dwcfg  = cfg_data[DSZ-1:0];
            endcase
        end
        m_done = 1'b0;
        step_v = m_fstep[ASZ-1] ? longint'(m_fstep) - (longint'(1) << ASZ) : longint'(m_fstep);
        if (abort) begin
            m_state = 0;
        end else if (start && m_state != 1) begin
            if (step_v == 0 || m_fstart == m_fstop) begin
                m_state = 2; m_done = 1'b1;
            end else begin
                m_state = 1; m_fcur = m_fstart; m_dwell = longint'(m_dwcfg);
            end
        end else if (m_state == 1 && ena) begin
            if (m_dwell > 1) begin
                m_dwell--;
            end else begin
                nxt = longint'(m_fcur) + step_v;
                if ((step_v > 0 && nxt >= longint'(m_fstop)) || (step_v < 0 && nxt <= longint'(m_fstop))) begin
                    m_state = 2; m_done = 1'b1;
                end else begin
                    m_fcur  = nxt[ASZ-1:0];
                    m_dwell = longint'(m_dwcfg);
                end
            end
        end
        if (m_state == 0) m_fcur = m_fstart;
        if (m_state == 2) m_fcur = m_fstop;
        m_acc   = acc_n;
        m_ready = (m_state != 1);
        m_vp    = {m_vp[LAT-1:0], ena};
    endtask

    task automatic apply_stimulus(input logic r, input logic we, input logic [1:0] a,
                                  input logic [ASZ-1:0] d, input logic st, input logic ab,
                                  input logic clr, input logic en);
        exp_t e;
        reset = r; cfg_we = we; cfg_addr = a; cfg_data = d;
        start = st; abort = ab; phs_clr = clr; ena = en;
        model_clock();
        e.phs   = m_acc[ASZ-1 -: PSZ];
        e.busy  = (m_state == 1);
        e.done  = m_done;
        e.ready = m_ready;
        e.ov    = m_vp[LAT];
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL scoreboard: got empty queue, want one entry");
            return;
        end
        e = sb.pop_front();
        check_val("sb_phs",       32'(phs),       32'(e.phs));
        check_val("sb_busy",      32'(busy),      32'(e.busy));
        check_val("sb_done",      32'(done),      32'(e.done));
        check_val("sb_cfg_ready", 32'(cfg_ready), 32'(e.ready));
        check_val("sb_out_valid", 32'(out_valid), 32'(e.ov));
    endtask

    task automatic cyc(input logic en);
        apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, en);
    endtask

    task automatic wr(input logic [1:0] a, input logic [ASZ-1:0] d);
        apply_stimulus(1'b0, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_vec(input logic we, input logic [1:0] a, input logic [ASZ-1:0] d,
                           input logic st, input logic en, input int stp,
                           input logic b, input logic dn);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.start = st; v.ena = en;
        v.step = stp; v.busy = b; v.done = dn;
        tbl.push_back(v);
    endtask

    initial begin
        logic [PSZ-1:0] prev;
        logic [PSZ-1:0] dlt;
        logic           wrap_seen;
        int             ov_at;

        // Sweep up (0x40000 -> 0x100000, +0x40000, dwell 4) then sweep down from HOLD
        add_vec(1, ADDR_FSTART, 26'h0040000, 0, 0, 0, 0, 0);
        add_vec(1, ADDR_FSTOP,  26'h0100000, 0, 0, 0, 0, 0);
        add_vec(1, ADDR_FSTEP,  26'h0040000, 0, 0, 0, 0, 0);
        add_vec(1, ADDR_DWELL,  26'd4,       0, 0, 0, 0, 0);
        add_vec(0, 2'd0, '0, 1, 1, 16, 1, 0);
        for (int k = 0; k < 4; k++) add_vec(0, 2'd0, '0, 0, 1, 16, 1, 0);
        for (int k = 0; k < 4; k++) add_vec(0, 2'd0, '0, 0, 1, 32, 1, 0);
        for (int k = 0; k < 3; k++) add_vec(0, 2'd0, '0, 0, 1, 48, 1, 0);
        add_vec(0, 2'd0, '0, 0, 1, 48, 0, 1);
        add_vec(0, 2'd0, '0, 0, 1, 64, 0, 0);
        add_vec(0, 2'd0, '0, 0, 1, 64, 0, 0);
        add_vec(1, ADDR_FSTART, 26'h0100000, 0, 0, 0, 0, 0);
        add_vec(1, ADDR_FSTOP,  26'h0050000, 0, 0, 0, 0, 0);
        add_vec(1, ADDR_FSTEP,  26'h3FC0000, 0, 0, 0, 0, 0);
        add_vec(1, ADDR_DWELL,  26'd1,       0, 0, 0, 0, 0);
        add_vec(0, 2'd0, '0, 1, 1, 20, 1, 0);
        add_vec(0, 2'd0, '0, 0, 1, 64, 1, 0);
        add_vec(0, 2'd0, '0, 0, 1, 48, 1, 0);
        add_vec(0, 2'd0, '0, 0, 1, 32, 0, 1);
        add_vec(0, 2'd0, '0, 0, 1, 20, 0, 0);
        add_vec(0, 2'd0, '0, 0, 1, 20, 0, 0);

        // Reset state, then cfg_ready comes up one cycle later
        do_reset();
        check_val("rst_phs",       32'(phs),       32'd0);
        check_val("rst_busy",      32'(busy),      32'd0);
        check_val("rst_done",      32'(done),      32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        cyc(1'b0);
        check_val("cfg_ready_after_rst", 32'(cfg_ready), 32'd1);

        // Tone: FSTART=0x40000 gives a phase step of 16 and wraps 4080 -> 0
        wr(ADDR_FSTART, 26'h0040000);
        prev = phs; wrap_seen = 1'b0; ov_at = -1;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1);
            dlt = phs - prev;
            check_val("tone_step", 32'(dlt), 32'd16);
            if (prev == 12'd4080 && phs == 12'd0) wrap_seen = 1'b1;
            if (out_valid && ov_at < 0) ov_at = i + 1;
            prev = phs;
        end
        check_val("tone_wrap", 32'(wrap_seen), 32'd1);
        check_val("tone_valid_latency", 32'(ov_at), 32'(LAT + 1));

        // Table-driven sweeps
        do_reset();
        cyc(1'b0);
        prev = phs;
        foreach (tbl[i]) begin
            apply_stimulus(1'b0, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].start, 1'b0, 1'b0, tbl[i].ena);
            dlt = phs - prev;
            check_val($sformatf("tbl%0d_step", i), 32'(dlt), 32'(tbl[i].step));
            check_val($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check_val($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
            prev = phs;
        end

        // Abort + start together mid-sweep; a write during SWEEP is dropped
        do_reset();
        cyc(1'b0);
        wr(ADDR_FSTART, 26'h0040000);
        wr(ADDR_FSTOP,  26'h0400000);
        wr(ADDR_FSTEP,  26'h0040000);
        wr(ADDR_DWELL,  26'd2);
        apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1);
        apply_stimulus(1'b0, 1'b1, ADDR_FSTART, 26'h0080000, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("abort_busy",      32'(busy),      32'd0);
        check_val("abort_done",      32'(done),      32'd0);
        check_val("abort_cfg_ready", 32'(cfg_ready), 32'd1);
        prev = phs;
        cyc(1'b1);
        dlt = phs - prev;
        check_val("abort_fstart_kept", 32'(dlt), 32'd16);

        // FSTEP=0 goes straight to HOLD with done; phs_clr zeroes phase only
        wr(ADDR_FSTEP, 26'd0);
        apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("zstep_busy", 32'(busy), 32'd0);
        check_val("zstep_done", 32'(done), 32'd1);
        cyc(1'b0);
        check_val("zstep_done_once", 32'(done), 32'd0);
        apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("hold_clr_phs",  32'(phs),       32'd0);
        check_val("hold_clr_rdy",  32'(cfg_ready), 32'd1);
        wr(ADDR_FSTEP, 26'h0040000);
        apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1);
        cyc(1'b1);
        apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("sweep_clr_phs",  32'(phs),  32'd0);
        check_val("sweep_clr_busy", 32'(busy), 32'd1);

        // Reset in the middle of a sweep
        cyc(1'b1);
        apply_stimulus(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("midrst_phs",       32'(phs),       32'd0);
        check_val("midrst_busy",      32'(busy),      32'd0);
        check_val("midrst_done",      32'(done),      32'd0);
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            check_val("midrst_no_done", 32'(done), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
